// File: rtl/clk_gen_pkg.sv
// Shared definitions for the programmable clock/strobe generator.
// Holds the FSM state type, the {period, high} config record, reset defaults
// and the config validity rule used by the pending-config slot.
package clk_gen_pkg;

  // Width of config fields carried in cfg_t.
  localparam int CFG_W = 16;

  // Waveform loaded into the active config at reset.
  localparam int DEF_PERIOD = 20;
  localparam int DEF_HIGH   = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  typedef struct packed {
    logic [CFG_W-1:0] period;
    logic [CFG_W-1:0] high;
  } cfg_t;

  // A period needs at least one high and one low cycle.
  function automatic logic cfg_is_valid(input logic [CFG_W-1:0] period,
                                        input logic [CFG_W-1:0] high);
    return (period >= CFG_W'(2)) && (high != '0) && (high < period);
  endfunction

endpackage

// File: rtl/clk_gen_cfg_slot.sv
// Pending-config slot: single-entry holding register with valid/ready handshake.
// Ports: cfg_valid_i/cfg_i offered config, cfg_ready_o free slot, cfg_err_o reject pulse,
//        bypass_i direct-load window, load_i period start, load_vld_o/load_cfg_o config to load,
//        direct_vld_o config written straight to the active config.
module clk_gen_cfg_slot
  import clk_gen_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic cfg_valid_i,
  input  cfg_t cfg_i,
  input  logic bypass_i,
  input  logic load_i,
  output logic cfg_ready_o,
  output logic cfg_err_o,
  output logic load_vld_o,
  output cfg_t load_cfg_o,
  output logic direct_vld_o
);

  logic pend_vld_q, pend_vld_d;
  cfg_t pend_q, pend_d;
  logic err_q, err_d;
  logic xfer;
  logic cfg_ok;

  assign xfer   = cfg_valid_i & ~pend_vld_q;
  assign cfg_ok = cfg_is_valid(cfg_i.period, cfg_i.high);

  // While idle and not requested to run there is no period start to wait for,
  // so an accepted config bypasses the slot and goes straight to active.
  assign direct_vld_o = xfer & cfg_ok & bypass_i;

  always_comb begin
    pend_vld_d = pend_vld_q;
    pend_d     = pend_q;
    err_d      = xfer & ~cfg_ok;
    if (load_i) begin
      pend_vld_d = 1'b0;
    end
    // A transfer only happens with the slot empty, so a transfer coinciding
    // with a period start never collides with the entry being loaded.
    if (xfer && cfg_ok && !bypass_i) begin
      pend_vld_d = 1'b1;
      pend_d     = cfg_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_vld_q <= 1'b0;
      pend_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      pend_vld_q <= pend_vld_d;
      pend_q     <= pend_d;
      err_q      <= err_d;
    end
  end

  assign cfg_ready_o = ~pend_vld_q;
  assign cfg_err_o   = err_q;
  assign load_vld_o  = load_i & pend_vld_q;
  assign load_cfg_o  = pend_q;

endmodule

// File: rtl/clk_period_gen.sv
// Programmable divided-clock generator: period and high time in clk cycles,
// config changes applied only at period boundaries so every period is whole.
// Ports: en run request; cfg_* config handshake; clk_out/tick waveform; busy,
//        period_cnt (completed periods), cur_period (active period).
module clk_period_gen #(
  parameter int CNT_W      = clk_gen_pkg::CFG_W,
  parameter int DEF_PERIOD = clk_gen_pkg::DEF_PERIOD,
  parameter int DEF_HIGH   = clk_gen_pkg::DEF_HIGH,
  parameter int PCNT_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CNT_W-1:0]  cfg_period,
  input  logic [CNT_W-1:0]  cfg_high,
  output logic              cfg_err,
  output logic              clk_out,
  output logic              tick,
  output logic              busy,
  output logic [PCNT_W-1:0] period_cnt,
  output logic [CNT_W-1:0]  cur_period
);
  import clk_gen_pkg::*;

  // Config records are CFG_W wide; the counter width must match them.
  if (CNT_W != CFG_W) begin : g_bad_cnt_w
    $error("CNT_W must equal clk_gen_pkg::CFG_W");
  end

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  cfg_t               act_q, act_d;
  logic [PCNT_W-1:0]  pcnt_q, pcnt_d;
  logic               clk_out_q, clk_out_d;
  logic               tick_q, tick_d;
  logic               start;   // next cycle is the first cycle of a period
  logic               wrap;    // this cycle is the last cycle of a period
  logic               load_vld, direct_vld;
  cfg_t               load_cfg, cfg_in;

  assign cfg_in = '{period: cfg_period, high: cfg_high};

  clk_gen_cfg_slot u_slot (
    .clk          (clk),
    .rst          (rst),
    .cfg_valid_i  (cfg_valid),
    .cfg_i        (cfg_in),
    .bypass_i     ((state_q == IDLE) && !en),
    .load_i       (start),
    .cfg_ready_o  (cfg_ready),
    .cfg_err_o    (cfg_err),
    .load_vld_o   (load_vld),
    .load_cfg_o   (load_cfg),
    .direct_vld_o (direct_vld)
  );

  // State register, plus the registered outputs derived from next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      act_q     <= '{period: CNT_W'(DEF_PERIOD), high: CNT_W'(DEF_HIGH)};
      pcnt_q    <= '0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      act_q     <= act_d;
      pcnt_q    <= pcnt_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end

  // Next-state logic. The counter runs 1..period across HIGH then LOW.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    start   = 1'b0;
    wrap    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (en) begin
          state_d = HIGH;
          cnt_d   = CNT_W'(1);
          start   = 1'b1;
        end
      end
      HIGH: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == act_q.high) begin
          state_d = LOW;
        end
      end
      LOW: begin
        if (cnt_q == act_q.period) begin
          wrap = 1'b1;
          if (en) begin
            state_d = HIGH;
            cnt_d   = CNT_W'(1);
            start   = 1'b1;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    act_d = act_q;
    if (load_vld) begin
      act_d = load_cfg;
    end else if (direct_vld) begin
      act_d = cfg_in;
    end

    pcnt_d = wrap ? pcnt_q + PCNT_W'(1) : pcnt_q;
  end

  // Output logic. clk_out and tick come from flops so the waveform is glitch-free.
  always_comb begin
    clk_out_d  = (state_d == HIGH);
    tick_d     = start;
    busy       = (state_q != IDLE);
    clk_out    = clk_out_q;
    tick       = tick_q;
    period_cnt = pcnt_q;
    cur_period = act_q.period;
  end

endmodule

// File: tb/tb_clk_period_gen.sv
module tb_clk_period_gen;

  localparam int CNT_W  = 16;
  localparam int PCNT_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [CNT_W-1:0]  cfg_period;
  logic [CNT_W-1:0]  cfg_high;
  logic              cfg_err;
  logic              clk_out;
  logic              tick;
  logic              busy;
  logic [PCNT_W-1:0] period_cnt;
  logic [CNT_W-1:0]  cur_period;

  always #5 clk = ~clk;

  clk_period_gen #(
    .CNT_W      (CNT_W),
    .DEF_PERIOD (20),
    .DEF_HIGH   (10),
    .PCNT_W     (PCNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_period (cfg_period),
    .cfg_high   (cfg_high),
    .cfg_err    (cfg_err),
    .clk_out    (clk_out),
    .tick       (tick),
    .busy       (busy),
    .period_cnt (period_cnt),
    .cur_period (cur_period)
  );

  int n_chk = 0;
  int n_bad = 0;

  // Reference model: position within the current period (0-based) plus
  // active/pending config; waveform is derived arithmetically from position.
  bit          m_run;
  int          m_t;
  int          m_ap, m_ah;
  bit          m_pv;
  int          m_pp, m_ph;
  bit          m_err;
  logic [31:0] m_pcnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run  = 1'b0;
    m_t    = 0;
    m_ap   = 20;
    m_ah   = 10;
    m_pv   = 1'b0;
    m_pp   = 0;
    m_ph   = 0;
    m_err  = 1'b0;
    m_pcnt = '0;
  endtask

  task automatic model_step(input bit e, input bit cv, input int cp, input int ch);
    bit was_run = m_run;
    bit last    = m_run && (m_t == m_ap - 1);
    bit start   = e && (!m_run || last);
    bit xfer    = cv && !m_pv;
    bit ok      = (cp >= 2) && (ch >= 1) && (ch < cp);
    if (last) m_pcnt = m_pcnt + 1;
    if (!m_run) m_run = e;
    else if (last) m_run = e;
    m_t = start ? 0 : (m_run ? m_t + 1 : 0);
    if (start && m_pv) begin
      m_ap = m_pp;
      m_ah = m_ph;
      m_pv = 1'b0;
    end
    if (xfer && ok) begin
      if (!was_run && !e) begin
        m_ap = cp;
        m_ah = ch;
      end else begin
        m_pp = cp;
        m_ph = ch;
        m_pv = 1'b1;
      end
    end
    m_err = xfer && !ok;
  endtask

  task automatic check_all();
    chk("clk_out",    32'(clk_out),    32'(m_run && (m_t < m_ah)));
    chk("tick",       32'(tick),       32'(m_run && (m_t == 0)));
    chk("busy",       32'(busy),       32'(m_run));
    chk("cfg_ready",  32'(cfg_ready),  32'(!m_pv));
    chk("cfg_err",    32'(cfg_err),    32'(m_err));
    chk("period_cnt", period_cnt,      m_pcnt);
    chk("cur_period", 32'(cur_period), 32'(m_ap));
  endtask

  // Starts and ends at a negedge: drive, clock, update model, then compare.
  task automatic cyc(input bit e, input bit cv, input int cp, input int ch);
    en         = e;
    cfg_valid  = cv;
    cfg_period = CNT_W'(cp);
    cfg_high   = CNT_W'(ch);
    @(posedge clk);
    model_step(e, cv, cp, ch);
    #1;
    check_all();
    @(negedge clk);
  endtask

  // Asserted mid-cycle so the asynchronous clear is observed immediately.
  task automatic do_reset();
    rst       = 1'b1;
    en        = 1'b0;
    cfg_valid = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bit run_en;
    int p, h;
    rst        = 1'b1;
    en         = 1'b0;
    cfg_valid  = 1'b0;
    cfg_period = '0;
    cfg_high   = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    rst = 1'b0;

    // Default 20/10 waveform, first rise one cycle after en.
    repeat (45) cyc(1, 0, 0, 0);
    // Mid-period config change 10/5.
    cyc(1, 1, 10, 5);
    repeat (40) cyc(1, 0, 0, 0);
    // Invalid configs are rejected.
    cyc(1, 1, 8, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 1, 1, 1);
    repeat (5) cyc(1, 0, 0, 0);
    // Fastest waveform 2/1.
    cyc(1, 1, 2, 1);
    repeat (30) cyc(1, 0, 0, 0);
    // Back to 20/10, then drop en in the third HIGH cycle.
    cyc(1, 1, 20, 10);
    repeat (25) cyc(1, 0, 0, 0);
    for (int i = 0; i < 100 && !(m_run && m_t == 2); i++) cyc(1, 0, 0, 0);
    repeat (25) cyc(0, 0, 0, 0);
    // Direct load while idle, then run it.
    cyc(0, 1, 6, 2);
    repeat (14) cyc(1, 0, 0, 0);
    // Reset in the middle of a LOW phase of a default period.
    do_reset();
    repeat (15) cyc(1, 0, 0, 0);
    do_reset();
    repeat (45) cyc(1, 0, 0, 0);

    // Randomized traffic.
    run_en = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 39) == 0) run_en = !run_en;
      if ($urandom_range(0, 3) == 0) p = $urandom_range(15, 40);
      else p = $urandom_range(0, 14);
      h = $urandom_range(0, p + 1);
      if ($urandom_range(0, 599) == 0) do_reset();
      else cyc(run_en, $urandom_range(0, 5) == 0, p, h);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
